// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: datapath widths, fetch stepping, fetch FSM states
// and the canonical NOP encoding.
package legv8_pkg;

    localparam int ADDR_WIDTH  = 64;
    localparam int INSTR_WIDTH = 32;
    localparam int PC_STEP     = 4;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'hD503201F;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID holding register: one instruction/PC entry with a valid flag,
// driven by load, squash and implicit hold controls.
module if_id_reg #(
    parameter int ADDR_WIDTH  = legv8_pkg::ADDR_WIDTH,
    parameter int INSTR_WIDTH = legv8_pkg::INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   squash,
    input  logic [INSTR_WIDTH-1:0] d_instr,
    input  logic [ADDR_WIDTH-1:0]  d_pc,
    output logic                   valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  pc
);

    // Squash only drops the valid flag; the stale payload is harmless once invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (squash) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= d_instr;
            pc    <= d_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: owns the PC, captures instructions into the
// IF/ID register, handles branch redirects and latches fetch-address faults.
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = legv8_pkg::ADDR_WIDTH,
    parameter int                    INSTR_WIDTH = legv8_pkg::INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    PC_STEP     = legv8_pkg::PC_STEP,
    parameter int                    MEM_BYTES   = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ADDR_WIDTH-1:0]  read_address,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic                   if_valid,
    input  logic                   id_ready,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0]  if_pc,
    output logic                   fault,
    output logic [ADDR_WIDTH-1:0]  fault_pc,
    output logic [31:0]            fetch_count
);

    import legv8_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(MEM_BYTES - 4);

    fetch_state_t          state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next;
    logic                  can_load;
    logic                  pc_illegal;
    logic                  do_load;
    logic                  do_squash;
    logic                  do_fault;

    assign can_load     = !if_valid || id_ready;
    assign pc_illegal   = (pc[1:0] != 2'b00) || (pc > LAST_PC);
    assign read_address = pc;

    // Priority in RUN: branch redirect, then fault check, then load, else hold.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        do_load    = 1'b0;
        do_squash  = 1'b0;
        do_fault   = 1'b0;
        case (state)
            RUN: begin
                if (branch_taken) begin
                    do_squash = 1'b1;
                    pc_next   = branch_target;
                end else if (can_load) begin
                    if (pc_illegal) begin
                        do_fault   = 1'b1;
                        do_squash  = 1'b1;
                        state_next = FAULT;
                    end else begin
                        do_load = 1'b1;
                        pc_next = pc + ADDR_WIDTH'(PC_STEP);
                    end
                end
            end
            FAULT: begin
                if (if_valid && id_ready) begin
                    do_squash = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // The fault flag is sticky; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault    <= 1'b0;
            fault_pc <= '0;
        end else if (do_fault) begin
            fault    <= 1'b1;
            fault_pc <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (do_load && (fetch_count != 32'hFFFF_FFFF)) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    if_id_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INSTR_WIDTH(INSTR_WIDTH)
    ) u_if_id_reg (
        .clk    (clk),
        .reset  (reset),
        .load   (do_load),
        .squash (do_squash),
        .d_instr(instruction),
        .d_pc   (pc),
        .valid  (if_valid),
        .instr  (if_instr),
        .pc     (if_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a behavioural instruction
// memory that answers 50 time units after each address change.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [63:0] read_address;
    logic [31:0] instruction;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        fault;
    logic [63:0] fault_pc;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .MEM_BYTES(128)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .read_address (read_address),
        .instruction  (instruction),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .if_valid     (if_valid),
        .id_ready     (id_ready),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .fault        (fault),
        .fault_pc     (fault_pc),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Memory contents: first four words from the program, then an address-tagged pattern.
    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        if (addr >= 64'd128) return 32'h0000_0000;
        case (addr[6:2])
            5'd0:    return 32'h8B1F03E5;
            5'd1:    return 32'hF84000A4;
            5'd2:    return 32'h8B040086;
            5'd3:    return 32'hF80010A6;
            default: return 32'hA000_0000 | {25'd0, addr[6:2], 2'b00};
        endcase
    endfunction

    initial begin
        instruction = mem_word(64'd0);
        forever begin
            @(read_address);
            #50;
            instruction = mem_word(read_address);
        end
    end

    task automatic applyStimulus(input logic br, input logic [63:0] tgt,
                                 input logic rdy, input logic rst);
        branch_taken  = br;
        branch_target = tgt;
        id_ready      = rdy;
        reset         = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        branch_taken  = 1'b0;
        branch_target = '0;
        id_ready      = 1'b1;
        reset         = 1'b1;

        applyStimulus(1'b0, 64'd0, 1'b1, 1'b1);
        checkOutput("rst_addr",  read_address, 64'd0);
        checkOutput("rst_valid", {63'd0, if_valid}, 64'd0);
        checkOutput("rst_instr", {32'd0, if_instr}, 64'd0);
        checkOutput("rst_fault", {63'd0, fault}, 64'd0);
        checkOutput("rst_count", {32'd0, fetch_count}, 64'd0);

        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
        checkOutput("first_instr", {32'd0, if_instr}, 64'h8B1F03E5);
        checkOutput("first_pc",    if_pc, 64'd0);
        checkOutput("first_valid", {63'd0, if_valid}, 64'd1);
        checkOutput("first_addr",  read_address, 64'd4);
        checkOutput("first_count", {32'd0, fetch_count}, 64'd1);

        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
        checkOutput("second_instr", {32'd0, if_instr}, 64'hF84000A4);
        checkOutput("second_pc",    if_pc, 64'd4);
        checkOutput("second_count", {32'd0, fetch_count}, 64'd2);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
            checkOutput("hold_pc",    if_pc, 64'd4);
            checkOutput("hold_instr", {32'd0, if_instr}, 64'hF84000A4);
            checkOutput("hold_addr",  read_address, 64'd8);
            checkOutput("hold_valid", {63'd0, if_valid}, 64'd1);
            checkOutput("hold_count", {32'd0, fetch_count}, 64'd2);
        end

        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
        checkOutput("resume_pc",    if_pc, 64'd8);
        checkOutput("resume_instr", {32'd0, if_instr}, 64'h8B040086);
        checkOutput("resume_count", {32'd0, fetch_count}, 64'd3);

        applyStimulus(1'b1, 64'd0, 1'b1, 1'b0);
        checkOutput("br_valid", {63'd0, if_valid}, 64'd0);
        checkOutput("br_addr",  read_address, 64'd0);
        checkOutput("br_count", {32'd0, fetch_count}, 64'd3);

        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
        checkOutput("br_tgt_pc",    if_pc, 64'd0);
        checkOutput("br_tgt_instr", {32'd0, if_instr}, 64'h8B1F03E5);
        checkOutput("br_tgt_valid", {63'd0, if_valid}, 64'd1);
        checkOutput("br_tgt_count", {32'd0, fetch_count}, 64'd4);

        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
            checkOutput("line_pc",    if_pc, 64'(4 * i));
            checkOutput("line_instr", {32'd0, if_instr}, {32'd0, mem_word(64'(4 * i))});
            checkOutput("line_count", {32'd0, fetch_count}, 64'(4 + i));
        end
        checkOutput("line_last", {32'd0, if_instr}, 64'hF80010A6);

        applyStimulus(1'b1, 64'd6, 1'b1, 1'b0);
        checkOutput("mis_br_valid", {63'd0, if_valid}, 64'd0);
        checkOutput("mis_br_addr",  read_address, 64'd6);
        checkOutput("mis_br_fault", {63'd0, fault}, 64'd0);

        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
        checkOutput("mis_fault",    {63'd0, fault}, 64'd1);
        checkOutput("mis_fault_pc", fault_pc, 64'd6);
        checkOutput("mis_valid",    {63'd0, if_valid}, 64'd0);
        checkOutput("mis_addr",     read_address, 64'd6);
        checkOutput("mis_count",    {32'd0, fetch_count}, 64'd7);

        applyStimulus(1'b1, 64'd0, 1'b1, 1'b0);
        checkOutput("flt_br_addr",  read_address, 64'd6);
        checkOutput("flt_br_fault", {63'd0, fault}, 64'd1);
        checkOutput("flt_br_valid", {63'd0, if_valid}, 64'd0);

        applyStimulus(1'b1, 64'd0, 1'b1, 1'b1);
        checkOutput("flt_rst_addr",    read_address, 64'd0);
        checkOutput("flt_rst_fault",   {63'd0, fault}, 64'd0);
        checkOutput("flt_rst_fault_pc", fault_pc, 64'd0);
        checkOutput("flt_rst_count",   {32'd0, fetch_count}, 64'd0);
        checkOutput("flt_rst_valid",   {63'd0, if_valid}, 64'd0);

        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
            checkOutput("seq_pc",    if_pc, 64'(4 * i));
            checkOutput("seq_instr", {32'd0, if_instr}, {32'd0, mem_word(64'(4 * i))});
            checkOutput("seq_valid", {63'd0, if_valid}, 64'd1);
            checkOutput("seq_count", {32'd0, fetch_count}, 64'(i + 1));
        end
        checkOutput("seq_end_pc",   if_pc, 64'h7C);
        checkOutput("seq_end_addr", read_address, 64'h80);

        applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
        checkOutput("oor_fault",    {63'd0, fault}, 64'd1);
        checkOutput("oor_fault_pc", fault_pc, 64'h80);
        checkOutput("oor_count",    {32'd0, fetch_count}, 64'd32);
        checkOutput("oor_valid",    {63'd0, if_valid}, 64'd0);
        checkOutput("oor_addr",     read_address, 64'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the LEGv8 CPU. It sits directly upstream of instruction_memory and directly downstream of it as well.
- It owns the program counter and drives it onto instruction_memory.read_address.
- It samples the returned 32-bit instruction into an IF/ID holding register with a valid/ready handshake toward decode.
- It handles taken-branch redirects from decode, and latches a fault on misaligned or out-of-range fetch addresses.

Parameters:
ADDR_WIDTH, 64, width of PC and read_address
INSTR_WIDTH, 32, instruction width
RESET_PC, 64'h0, PC value after reset
PC_STEP, 4, sequential PC increment in bytes
MEM_BYTES, 128, instruction memory size in bytes; valid fetch PCs are 0..MEM_BYTES-4

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
read_address  output  ADDR_WIDTH  to instruction_memory; equals current PC register
instruction  input  INSTR_WIDTH  from instruction_memory; valid within 50 time units of read_address change
branch_taken  input  1  decode requests redirect this cycle
branch_target  input  ADDR_WIDTH  redirect PC; sampled only when branch_taken=1
if_valid  output  1  IF/ID entry holds an instruction for decode
id_ready  input  1  decode accepts entry this cycle (transfer = if_valid && id_ready)
if_instr  output  INSTR_WIDTH  captured instruction
if_pc  output  ADDR_WIDTH  PC of if_instr
fault  output  1  sticky fetch-address fault
fault_pc  output  ADDR_WIDTH  offending PC
fetch_count  output  32  number of instructions captured; saturates at 32'hFFFFFFFF

Behaviour:
- Single clock; all state updates on rising clk. Clock period must exceed the memory access delay; the bench uses period 100 against the 50-unit delay.
- Reset (synchronous, active-high), values at the edge where reset=1:
  - PC=RESET_PC; if_valid=0; if_instr=0; if_pc=0
  - fault=0; fault_pc=0; fetch_count=0; state=RUN
  - Reset overrides every other input, including mid-stall or mid-fault.
- States: RUN, FAULT. Only reset leaves FAULT.
- can_load = !if_valid || id_ready.
- Priority each edge in RUN: reset > branch_taken > fault check > load > hold.
- branch_taken=1 (RUN):
  - if_valid<=0 (squash the wrong-path entry regardless of id_ready); PC<=branch_target.
  - No capture this cycle; fetch_count unchanged.
  - The target is checked on the following cycle as the new PC.
- Fault check in RUN, when can_load=1: if PC[1:0]!=0 or PC>MEM_BYTES-4:
  - state<=FAULT; fault<=1; fault_pc<=PC; if_valid<=0.
  - PC holds. No capture.
- Load (RUN, can_load=1, PC legal):
  - if_instr<=instruction; if_pc<=PC; if_valid<=1.
  - PC<=PC+PC_STEP (modulo 2^ADDR_WIDTH; an out-of-range result is caught by the next fault check).
  - fetch_count<=sat(fetch_count+1).
- Hold (RUN, if_valid=1, id_ready=0): PC, if_instr, if_pc, if_valid unchanged; the instruction bus is ignored.
- FAULT:
  - PC frozen; branch_taken ignored.
  - An existing entry is cleared on transfer; otherwise it is held.
  - No new loads.
- Throughput: one instruction per cycle with id_ready held at 1. First if_valid=1 appears one edge after reset deasserts.
- read_address is a direct register output (no combinational path from inputs).

Decomposition:
- Shared package legv8_pkg holds:
  - ADDR_WIDTH and INSTR_WIDTH constants
  - PC_STEP
  - the fetch-state enum {RUN, FAULT}
  - a NOP encoding constant, used later by decode
- One natural sub-module: if_id_reg, the valid/ready holding register carrying if_instr/if_pc/if_valid with load/squash/hold controls.
- The PC and FSM stay in fetch_unit.

Test Plan:
- Reset then release; memory bytes 0..3 = E5 03 1F 8B, id_ready=1 -> read_address=0 during reset. After first edge: if_instr=32'h8B1F03E5, if_pc=0, if_valid=1, read_address=4, fetch_count=1.
- Straight-line run, id_ready=1, four words at 0,4,8,12 -> if_instr sequence 8B1F03E5, F84000A4, 8B040086, F80010A6 on consecutive cycles; fetch_count=4.
- After the load at PC=4, hold id_ready=0 for 3 cycles -> if_pc=4, if_instr=F84000A4, read_address=8 stable. When id_ready=1: next edge loads PC=8.
- branch_taken=1, target=0x0 while if_pc=8 -> next edge if_valid=0, read_address=0. Following edge if_pc=0, if_instr=8B1F03E5.
- branch_taken=1, target=0x6 -> fault=1, fault_pc=6, if_valid=0 one edge later. Further branches ignored. reset restores RUN with read_address=0.
- Sequential run from 0 with MEM_BYTES=128 -> last capture if_pc=0x7C. Next edge: fault=1, fault_pc=0x80, fetch_count=32.
